// File: rtl/key_entry_buffer_if.sv
// ---------------------------------------------------------------------------
// key_entry_buffer_if
// Purpose : valid/ready event stream carrying one 4-bit key code per beat.
// Signals : evt_code  [3:0] key code at the queue head (0 while empty)
//           evt_valid       queue holds at least one event
//           evt_ready       consumer accepts the head when valid && ready
// Modports: master = event producer (key_entry_buffer)
//           slave  = downstream controller
// ---------------------------------------------------------------------------
interface key_entry_buffer_if;
    logic [3:0] evt_code;
    logic       evt_valid;
    logic       evt_ready;

    modport master (output evt_code, output evt_valid, input evt_ready);
    modport slave  (input evt_code, input evt_valid, output evt_ready);
endinterface

// File: rtl/key_entry_buffer.sv
// ---------------------------------------------------------------------------
// key_entry_buffer
// Purpose : turns clean presses on a debounced 16-key one-hot vector into
//           4-bit key events, maintains a 4-digit entry register for the
//           display driver and queues every event in a small FIFO.
// Ports   : i_clk        system clock, rising edge
//           i_rst        synchronous active-high reset
//           i_key_deb    [15:0] debounced key levels (bit i = key i held)
//           o_disp_data  [15:0] entry register, [3:0] is the newest digit
//           o_digit_cnt  [2:0]  number of valid digits (0..4)
//           o_ovf        one-cycle pulse on a digit entered with 4 digits held
//           o_evt_drop   sticky, an event was lost to a full FIFO
//           evt          key_entry_buffer_if.master event stream
// Config  : KEY_REPEAT_EN (macro) enables auto-repeat every REPEAT_DLY cycles
//           while a single key stays held.
// ---------------------------------------------------------------------------
module key_entry_buffer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned REPEAT_DLY = 25_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [15:0]                i_key_deb,
    output logic [15:0]                o_disp_data,
    output logic [2:0]                 o_digit_cnt,
    output logic                       o_ovf,
    output logic                       o_evt_drop,
    key_entry_buffer_if.master         evt
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || REPEAT_DLY < 2) begin : g_bad_cfg
        $error("key_entry_buffer: illegal FIFO_DEPTH or REPEAT_DLY");
    end

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LOCK} state_t;

    state_t        r_state;
    logic [15:0]   r_key_q;
    logic [3:0]    r_code;
    logic [15:0]   r_disp;
    logic [2:0]    r_cnt;
    logic          r_ovf;
    logic          r_drop;

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    logic          w_onehot;
    logic [3:0]    w_idx;
    logic          w_held_match;
    logic          w_press;
    logic          w_evt;
    logic [3:0]    w_evt_code;
    logic          w_valid;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (r_key_q[i]) w_idx = 4'(i);
        end
    end

    assign w_onehot     = (r_key_q != '0) && ((r_key_q & (r_key_q - 16'd1)) == '0);
    assign w_held_match = (r_key_q == (16'd1 << r_code));
    assign w_press      = (r_state == ST_IDLE) && w_onehot;

`ifdef KEY_REPEAT_EN
    localparam int unsigned CW = $clog2(REPEAT_DLY);
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_DLY - 1);

    logic [CW-1:0] r_rpt_cnt;
    logic          w_repeat;

    // Counter runs only while the latched key stays the sole key held; the
    // REPEAT_DLY-th such cycle fires a repeat and restarts the count.
    assign w_repeat   = (r_state == ST_HELD) && w_held_match && (r_rpt_cnt == RPT_LAST);
    assign w_evt      = w_press || w_repeat;
    assign w_evt_code = w_press ? w_idx : r_code;
`else
    assign w_evt      = w_press;
    assign w_evt_code = w_idx;
`endif

    // Key capture and press-tracking state machine
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key_q   <= '0;
            r_state   <= ST_LOCK;   // a key held across reset must be released first
            r_code    <= '0;
`ifdef KEY_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
        end else begin
            r_key_q <= i_key_deb;
            case (r_state)
                ST_IDLE: begin
                    if (w_onehot) begin
                        r_state <= ST_HELD;
                        r_code  <= w_idx;
                    end else if (r_key_q != '0) begin
                        r_state <= ST_LOCK;
                    end
                end
                ST_HELD: begin
                    if (r_key_q == '0)      r_state <= ST_IDLE;
                    else if (!w_held_match) r_state <= ST_LOCK;
                end
                default: begin
                    if (r_key_q == '0) r_state <= ST_IDLE;
                end
            endcase
`ifdef KEY_REPEAT_EN
            if (r_state == ST_HELD && w_held_match)
                r_rpt_cnt <= (r_rpt_cnt == RPT_LAST) ? '0 : r_rpt_cnt + CW'(1);
            else
                r_rpt_cnt <= '0;
`endif
        end
    end

    // Entry register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_evt) begin
                if (w_evt_code == 4'hF) begin
                    r_disp <= '0;
                    r_cnt  <= '0;
                end else if (w_evt_code == 4'hE) begin
                    r_disp <= {4'h0, r_disp[15:4]};
                    if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                end else begin
                    r_disp <= {r_disp[11:0], w_evt_code};
                    if (r_cnt != 3'd4) r_cnt <= r_cnt + 3'd1;
                    else               r_ovf <= 1'b1;
                end
            end
        end
    end

    // Event FIFO: a pop on the same edge frees the slot a full-queue push needs
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = w_valid && evt.evt_ready;
    assign w_push  = w_evt && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= w_evt_code;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_evt && !w_push) r_drop <= 1'b1;
        end
    end

    assign evt.evt_valid = w_valid;
    assign evt.evt_code  = w_valid ? r_mem[r_rd] : 4'h0;
    assign o_disp_data   = r_disp;
    assign o_digit_cnt   = r_cnt;
    assign o_ovf         = r_ovf;
    assign o_evt_drop    = r_drop;

endmodule
